// File: rtl/fdc_pkg.sv
// rtl/fdc_pkg.sv - shared state, status and mark-byte definitions for the sector reader
package fdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC_ID,
        ST_ID_FLD,
        ST_SYNC_DAM,
        ST_DATA,
        ST_DCRC
    } state_t;

    typedef enum logic [2:0] {
        STS_OK        = 3'd0,
        STS_NOT_FOUND = 3'd1,
        STS_ID_CRC    = 3'd2,
        STS_NO_DAM    = 3'd3,
        STS_DATA_CRC  = 3'd4,
        STS_DELETED   = 3'd5,
        STS_ABORT     = 3'd6,
        STS_SIZE      = 3'd7
    } status_t;

    localparam logic [7:0] MARK_A1   = 8'hA1;
    localparam logic [7:0] MARK_IDAM = 8'hFE;
    localparam logic [7:0] MARK_DAM  = 8'hFB;
    localparam logic [7:0] MARK_DDAM = 8'hF8;

endpackage

// File: rtl/mfm_sector_reader_if.sv
// rtl/mfm_sector_reader_if.sv - decoded byte stream in, sector buffer write port out
interface mfm_sector_reader_if;
    logic [7:0] in_data;
    logic       in_mark;
    logic       in_valid;
    logic       in_crc_ok;
    logic       wr_en;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output in_data, in_mark, in_valid, in_crc_ok,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_mark, in_valid, in_crc_ok,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/mfm_sector_reader_mark_sync.sv
// rtl/mfm_sector_reader_mark_sync.sv - triple A1 sync detector, flags the byte after the marks
module mfm_mark_sync (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       clear,
    input  logic       in_valid,
    input  logic       in_mark,
    input  logic [7:0] in_data,
    output logic       am_seen,
    output logic [7:0] am_byte
);
    logic [1:0] mark_cnt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            mark_cnt <= 2'd0;
        end else if (clear) begin
            mark_cnt <= 2'd0;
        end else if (in_valid) begin
            if (!in_mark)
                mark_cnt <= 2'd0;
            else if (mark_cnt != 2'd3)
                mark_cnt <= mark_cnt + 2'd1;
        end
    end

    assign am_seen = in_valid && !in_mark && !clear && (mark_cnt == 2'd3);
    assign am_byte = in_data;
endmodule

// File: rtl/mfm_sector_reader.sv
// rtl/mfm_sector_reader.sv - ID search, DAM wait and sector streaming with status report
module mfm_sector_reader
    import fdc_pkg::*;
#(
    parameter int MAX_N      = 2,
    parameter int REVS       = 2,
    parameter int DAM_WINDOW = 43
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          req_cyl,
    input  logic [7:0]          req_head,
    input  logic [7:0]          req_sec,
    input  logic                index_l,
    mfm_sector_reader_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic [2:0]          status,
    output logic [1:0]          size_n
);
    localparam int RW = $clog2(REVS + 1);
    localparam int WW = $clog2(DAM_WINDOW + 2);

    state_t      state, state_d;
    status_t     fin_code;
    logic        fin, wr_go;
    logic [9:0]  cnt;
    logic [7:0]  r_cyl, r_head, r_sec;
    logic [7:0]  id_c, id_h, id_r, id_n;
    logic [RW-1:0] rev_cnt;
    logic [WW-1:0] win_cnt;
    logic [2:0]  idx_sr;
    logic        idx_fall, rev_reached, deleted;
    logic        am_seen, id_last, id_match, win_over, sync_clear;
    logic [7:0]  am_byte;
    logic [10:0] sec_bytes;
    logic [9:0]  sec_last;

    assign sync_clear = (state != ST_SYNC_ID) && (state != ST_SYNC_DAM);

    mfm_mark_sync u_sync (
        .clk      (clk),
        .reset_l  (reset_l),
        .clear    (sync_clear),
        .in_valid (bus.in_valid),
        .in_mark  (bus.in_mark),
        .in_data  (bus.in_data),
        .am_seen  (am_seen),
        .am_byte  (am_byte)
    );

    // idx_sr[1] is the synchronised index level, idx_sr[2] its previous value
    assign idx_fall    = idx_sr[2] && !idx_sr[1];
    assign rev_reached = (int'(rev_cnt) + (idx_fall ? 1 : 0)) >= REVS;
    assign id_last     = bus.in_valid && (cnt == 10'd5);
    assign id_match    = (id_c == r_cyl) && (id_h == r_head) && (id_r == r_sec);
    assign win_over    = bus.in_valid && !bus.in_mark && (int'(win_cnt) >= DAM_WINDOW);
    assign sec_bytes   = 11'd128 << size_n;
    assign sec_last    = 10'(sec_bytes - 11'd1);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) state <= ST_IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d  = state;
        fin      = 1'b0;
        fin_code = STS_OK;
        wr_go    = 1'b0;
        if (state != ST_IDLE && abort) begin
            fin      = 1'b1;
            fin_code = STS_ABORT;
        end else begin
            case (state)
                ST_IDLE: if (start) state_d = ST_SYNC_ID;
                ST_SYNC_ID: begin
                    if (am_seen && am_byte == MARK_IDAM) state_d = ST_ID_FLD;
                    else if (rev_reached) begin fin = 1'b1; fin_code = STS_NOT_FOUND; end
                end
                ST_ID_FLD: begin
                    // a completed matching ID outranks an index edge in the same clock
                    if (id_last && !bus.in_crc_ok) begin fin = 1'b1; fin_code = STS_ID_CRC; end
                    else if (id_last && id_match && int'(id_n) > MAX_N) begin fin = 1'b1; fin_code = STS_SIZE; end
                    else if (id_last && id_match) state_d = ST_SYNC_DAM;
                    else if (rev_reached) begin fin = 1'b1; fin_code = STS_NOT_FOUND; end
                    else if (id_last) state_d = ST_SYNC_ID;
                end
                ST_SYNC_DAM: begin
                    if (am_seen && (am_byte == MARK_DAM || am_byte == MARK_DDAM)) state_d = ST_DATA;
                    else if ((am_seen && am_byte == MARK_IDAM) || win_over) begin
                        fin = 1'b1; fin_code = STS_NO_DAM;
                    end
                end
                ST_DATA: if (bus.in_valid) begin
                    wr_go = 1'b1;
                    if (cnt == sec_last) state_d = ST_DCRC;
                end
                ST_DCRC: if (bus.in_valid && cnt == 10'd1) begin
                    fin      = 1'b1;
                    fin_code = !bus.in_crc_ok ? STS_DATA_CRC : (deleted ? STS_DELETED : STS_OK);
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (fin) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            idx_sr <= 3'b111;
            bus.wr_en <= 1'b0; bus.wr_addr <= 10'd0; bus.wr_data <= 8'd0;
            done <= 1'b0; busy <= 1'b0; status <= 3'd0; size_n <= 2'd0;
            cnt <= 10'd0; rev_cnt <= '0; win_cnt <= '0; deleted <= 1'b0;
            r_cyl <= 8'd0; r_head <= 8'd0; r_sec <= 8'd0;
            id_c <= 8'd0; id_h <= 8'd0; id_r <= 8'd0; id_n <= 8'd0;
        end else begin
            idx_sr    <= {idx_sr[1:0], index_l};
            bus.wr_en <= wr_go;
            if (wr_go) begin
                bus.wr_addr <= cnt;
                bus.wr_data <= bus.in_data;
            end
            done <= fin;
            if (state_d != state) cnt <= 10'd0;
            else if (bus.in_valid) cnt <= cnt + 10'd1;
            if (state == ST_IDLE && start) begin
                r_cyl <= req_cyl; r_head <= req_head; r_sec <= req_sec;
                rev_cnt <= '0; busy <= 1'b1; status <= 3'd0; size_n <= 2'd0;
            end
            if (fin) begin
                busy   <= 1'b0;
                status <= fin_code;
            end
            if (idx_fall && (state == ST_SYNC_ID || state == ST_ID_FLD) && rev_cnt < RW'(REVS))
                rev_cnt <= rev_cnt + RW'(1);
            if (state == ST_ID_FLD && bus.in_valid) begin
                case (cnt)
                    10'd0:   id_c <= bus.in_data;
                    10'd1:   id_h <= bus.in_data;
                    10'd2:   id_r <= bus.in_data;
                    10'd3:   id_n <= bus.in_data;
                    default: ;
                endcase
            end
            if (state == ST_ID_FLD && state_d == ST_SYNC_DAM) size_n <= id_n[1:0];
            if (state != ST_SYNC_DAM) win_cnt <= '0;
            else if (bus.in_valid && !bus.in_mark && win_cnt < WW'(DAM_WINDOW + 1))
                win_cnt <= win_cnt + WW'(1);
            if (state == ST_SYNC_DAM && state_d == ST_DATA) deleted <= (am_byte == MARK_DDAM);
        end
    end
endmodule
